// File: rtl/sha1_sched_pkg.sv
// Shared types and constants for the SHA-1 message scheduler.
package sha1_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PAD,
    S_LEN,
    S_FIRE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [31:0] PAD_MARKER  = 32'h8000_0000;
  localparam logic [3:0]  LEN_SLOT_HI = 4'd14;
  localparam logic [3:0]  LEN_SLOT_LO = 4'd15;

endpackage

// File: rtl/sha1_pad_word.sv
// Final-word shaping: keeps the valid leading bytes, inserts the 0x80 marker
// right after them and zeroes the rest. last_bytes == 0 means a full word.
module sha1_pad_word
  import sha1_sched_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  last_bytes,
  output logic [31:0] word
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam int HI = 31 - 8 * gi;
      assign word[HI -: 8] = (last_bytes == 2'd0 || 2'(gi) < last_bytes) ? data[HI -: 8] :
                             (2'(gi) == last_bytes)                      ? PAD_MARKER[31:24] :
                                                                           8'h00;
    end
  endgenerate

endmodule

// File: rtl/sha1_msg_sched.sv
// SHA-1 message scheduler: streams words into core W slots, pads, appends the
// bit length and sequences core blocks. Optional watchdog: SHA1_SCHED_WDOG_EN.
module sha1_msg_sched
  import sha1_sched_pkg::*;
#(
  parameter int LEN_W   = 64,
  parameter int TIMEOUT = 4096
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        start,
  input  logic        empty_msg,
  input  logic [31:0] msg_data,
  input  logic        msg_valid,
  input  logic        msg_last,
  input  logic [1:0]  msg_last_bytes,
  output logic        msg_ready,
  output logic        core_we,
  output logic [3:0]  core_widx,
  output logic [31:0] core_wdata,
  output logic        core_start,
  output logic        core_init,
  input  logic        core_done,
  output logic        busy,
  output logic        done,
  output logic        irq,
  output logic        error,
  output logic [15:0] block_count
);

  state_t           state_reg, state_next;
  logic [3:0]       widx_reg, widx_next;
  logic [LEN_W-1:0] len_reg, len_next;
  logic             first_reg, first_next;
  logic             marker_reg, marker_next;   // 0x80 marker already written
  logic             msg_end_reg, msg_end_next; // no more message words to come
  logic             len_done_reg, len_done_next;
  logic [15:0]      blk_cnt_reg, blk_cnt_next;
  logic             done_reg, done_next;
  logic             irq_reg, irq_next;
  logic             error_reg, error_next;

  logic [31:0]      pad_word;
  logic [63:0]      len_field;
  logic [LEN_W-1:0] add_bits;
  logic             wd_fire;

  sha1_pad_word u_pad_word (
    .data       (msg_data),
    .last_bytes (msg_last_bytes),
    .word       (pad_word)
  );

  assign len_field = 64'(len_reg);
  assign add_bits  = (msg_last && msg_last_bytes != 2'd0) ? LEN_W'({msg_last_bytes, 3'b000})
                                                          : LEN_W'(6'd32);

`ifdef SHA1_SCHED_WDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt_reg;

  // Counts cycles since core_start, so the timeout lands TIMEOUT cycles after it.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || state_reg != S_WAIT) wd_cnt_reg <= WD_W'(1);
    else                                 wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
  end

  assign wd_fire = (state_reg == S_WAIT) && !core_done && (wd_cnt_reg == WD_W'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign wd_fire        = 1'b0;
`endif

  always_comb begin
    state_next    = state_reg;
    widx_next     = widx_reg;
    len_next      = len_reg;
    first_next    = first_reg;
    marker_next   = marker_reg;
    msg_end_next  = msg_end_reg;
    len_done_next = len_done_reg;
    blk_cnt_next  = blk_cnt_reg;
    done_next     = done_reg;
    irq_next      = 1'b0;
    error_next    = error_reg;
    msg_ready     = 1'b0;
    core_we       = 1'b0;
    core_wdata    = 32'h0;
    core_start    = 1'b0;
    core_init     = 1'b0;

    case (state_reg)
      S_IDLE, S_DONE: begin
        if (start) begin
          widx_next     = 4'd0;
          len_next      = '0;
          first_next    = 1'b1;
          marker_next   = 1'b0;
          msg_end_next  = empty_msg;
          len_done_next = 1'b0;
          blk_cnt_next  = 16'd0;
          done_next     = 1'b0;
          error_next    = 1'b0;
          state_next    = empty_msg ? S_PAD : S_LOAD;
        end
      end
      S_LOAD: begin
        msg_ready = 1'b1;
        if (msg_valid) begin
          core_we    = 1'b1;
          core_wdata = msg_last ? pad_word : msg_data;
          len_next   = len_reg + add_bits;
          widx_next  = widx_reg + 4'd1;
          if (msg_last) begin
            msg_end_next = 1'b1;
            marker_next  = (msg_last_bytes != 2'd0);
          end
          if (widx_reg == LEN_SLOT_LO)
            state_next = S_FIRE;
          else if (msg_last)
            state_next = (msg_last_bytes != 2'd0 && widx_reg == LEN_SLOT_HI - 4'd1) ? S_LEN : S_PAD;
        end
      end
      S_PAD: begin
        core_we     = 1'b1;
        core_wdata  = marker_reg ? 32'h0 : PAD_MARKER;
        marker_next = 1'b1;
        widx_next   = widx_reg + 4'd1;
        // A marker in slot 14/15 leaves no room for the length: fill and chain.
        if (widx_reg == LEN_SLOT_LO)              state_next = S_FIRE;
        else if (widx_reg == LEN_SLOT_HI - 4'd1)  state_next = S_LEN;
      end
      S_LEN: begin
        core_we    = 1'b1;
        core_wdata = (widx_reg == LEN_SLOT_HI) ? len_field[63:32] : len_field[31:0];
        widx_next  = widx_reg + 4'd1;
        if (widx_reg == LEN_SLOT_LO) begin
          len_done_next = 1'b1;
          state_next    = S_FIRE;
        end
      end
      S_FIRE: begin
        core_start   = 1'b1;
        core_init    = first_reg;
        first_next   = 1'b0;
        blk_cnt_next = (blk_cnt_reg == 16'hFFFF) ? blk_cnt_reg : blk_cnt_reg + 16'd1;
        state_next   = S_WAIT;
      end
      S_WAIT: begin
        if (core_done) begin
          if (!msg_end_reg) begin
            state_next = S_LOAD;
          end else if (len_done_reg) begin
            done_next  = 1'b1;
            irq_next   = 1'b1;
            state_next = S_DONE;
          end else begin
            state_next = S_PAD;
          end
        end else if (wd_fire) begin
          error_next = 1'b1;
          irq_next   = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_reg    <= S_IDLE;
      widx_reg     <= 4'd0;
      len_reg      <= '0;
      first_reg    <= 1'b0;
      marker_reg   <= 1'b0;
      msg_end_reg  <= 1'b0;
      len_done_reg <= 1'b0;
      blk_cnt_reg  <= 16'd0;
      done_reg     <= 1'b0;
      irq_reg      <= 1'b0;
      error_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      widx_reg     <= widx_next;
      len_reg      <= len_next;
      first_reg    <= first_next;
      marker_reg   <= marker_next;
      msg_end_reg  <= msg_end_next;
      len_done_reg <= len_done_next;
      blk_cnt_reg  <= blk_cnt_next;
      done_reg     <= done_next;
      irq_reg      <= irq_next;
      error_reg    <= error_next;
    end
  end

  assign core_widx   = widx_reg;
  assign busy        = (state_reg != S_IDLE) && (state_reg != S_DONE);
  assign done        = done_reg;
  assign irq         = irq_reg;
  assign error       = error_reg;
  assign block_count = blk_cnt_reg;

endmodule
